// File: rtl/jacobian_to_affine.sv
// Jacobian -> affine conversion for secp256k1 using a shared two-stage mod_mul and Fermat inversion.
// Optional J2A_Z1_BYPASS_EN: Z == 1 returns X/Y directly without any multiplies.

module mod_mul (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] a,
   input  logic [255:0] b,
   output logic [255:0] result,
   output logic         done
);
   localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
   // 2^256 mod P, used to fold the upper half back into the field
   localparam logic [32:0]  C = 33'h1000003D1;

   logic [511:0] prod_q, prod_d;
   logic         v_q, v_d;
   logic [255:0] res_q, res_d;
   logic         done_q, done_d;
   logic [289:0] t1;
   logic [256:0] t2;
   logic [255:0] t3;

   always_comb begin
      prod_d = start ? ({256'd0, a} * {256'd0, b}) : prod_q;
      v_d    = start;
      done_d = v_q;
      t1 = {34'd0, prod_q[255:0]} + ({34'd0, prod_q[511:256]} * {257'd0, C});
      t2 = {1'b0, t1[255:0]} + ({223'd0, t1[289:256]} * {224'd0, C});
      // a carry out of t2 leaves only a small remainder, so one more fold cannot overflow
      t3 = t2[255:0] + (t2[256] ? {223'd0, C} : 256'd0);
      res_d = res_q;
      if (v_q) res_d = (t3 >= P) ? (t3 - P) : t3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         v_q    <= 1'b0;
         res_q  <= '0;
         done_q <= 1'b0;
      end else begin
         prod_q <= prod_d;
         v_q    <= v_d;
         res_q  <= res_d;
         done_q <= done_d;
      end
   end

   assign result = res_q;
   assign done   = done_q;
endmodule

module jacobian_to_affine (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] X,
   input  logic [255:0] Y,
   input  logic [255:0] Z,
   output logic [255:0] x_out,
   output logic [255:0] y_out,
   output logic         is_inf,
   output logic         busy,
   output logic         done
);
   localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
   localparam logic [255:0] EXP = P - 256'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_SQ, S_MUL, S_ZI2, S_XM, S_ZI3, S_YM, S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [255:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
   logic [255:0] acc_q, acc_d, zi2_q, zi2_d;
   logic [7:0]   i_q, i_d;
   logic [255:0] x_out_q, x_out_d, y_out_q, y_out_d;
   logic         is_inf_q, is_inf_d;

   logic         mul_start, mul_done;
   logic [255:0] mul_a, mul_b, mul_result;

   mod_mul u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (mul_a),
      .b      (mul_b),
      .result (mul_result),
      .done   (mul_done)
   );

   always_comb begin
      state_d   = state_q;
      xr_d      = xr_q;
      yr_d      = yr_q;
      zr_d      = zr_q;
      acc_d     = acc_q;
      zi2_d     = zi2_q;
      i_d       = i_q;
      x_out_d   = x_out_q;
      y_out_d   = y_out_q;
      is_inf_d  = is_inf_q;
      mul_start = 1'b0;
      mul_a     = '0;
      mul_b     = '0;

      case (state_q)
         S_IDLE: if (start) begin
            xr_d     = X;
            yr_d     = Y;
            zr_d     = Z;
            is_inf_d = 1'b0;
            state_d  = S_CHECK;
         end
         S_CHECK: begin
            if (zr_q == '0) begin
               x_out_d  = '0;
               y_out_d  = '0;
               is_inf_d = 1'b1;
               state_d  = S_DONE;
            end
`ifdef J2A_Z1_BYPASS_EN
            else if (zr_q == 256'd1) begin
               x_out_d = xr_q;
               y_out_d = yr_q;
               state_d = S_DONE;
            end
`endif
            else begin
               acc_d     = zr_q;
               i_d       = 8'd254;
               state_d   = S_SQ;
               mul_start = 1'b1;
            end
         end
         S_SQ: if (mul_done) begin
            acc_d     = mul_result;
            mul_start = 1'b1;
            if (EXP[i_q])       state_d = S_MUL;
            else if (i_q == '0) state_d = S_ZI2;
            else                i_d     = i_q - 8'd1;
         end
         S_MUL: if (mul_done) begin
            acc_d     = mul_result;
            mul_start = 1'b1;
            if (i_q == '0) state_d = S_ZI2;
            else begin
               i_d     = i_q - 8'd1;
               state_d = S_SQ;
            end
         end
         S_ZI2: if (mul_done) begin
            zi2_d     = mul_result;
            state_d   = S_XM;
            mul_start = 1'b1;
         end
         S_XM: if (mul_done) begin
            x_out_d   = mul_result;
            state_d   = S_ZI3;
            mul_start = 1'b1;
         end
         S_ZI3: if (mul_done) begin
            acc_d     = mul_result;
            state_d   = S_YM;
            mul_start = 1'b1;
         end
         S_YM: if (mul_done) begin
            y_out_d = mul_result;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // operands follow the next state so a new multiply issues in the cycle the previous one completes
      case (state_d)
         S_SQ, S_ZI2: begin mul_a = acc_d; mul_b = acc_d; end
         S_MUL:       begin mul_a = acc_d; mul_b = zr_q;  end
         S_XM:        begin mul_a = xr_q;  mul_b = zi2_d; end
         S_ZI3:       begin mul_a = zi2_d; mul_b = acc_d; end
         S_YM:        begin mul_a = yr_q;  mul_b = acc_d; end
         default:     begin mul_a = '0;    mul_b = '0;    end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         xr_q     <= '0;
         yr_q     <= '0;
         zr_q     <= '0;
         acc_q    <= '0;
         zi2_q    <= '0;
         i_q      <= '0;
         x_out_q  <= '0;
         y_out_q  <= '0;
         is_inf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         xr_q     <= xr_d;
         yr_q     <= yr_d;
         zr_q     <= zr_d;
         acc_q    <= acc_d;
         zi2_q    <= zi2_d;
         i_q      <= i_d;
         x_out_q  <= x_out_d;
         y_out_q  <= y_out_d;
         is_inf_q <= is_inf_d;
      end
   end

   assign x_out  = x_out_q;
   assign y_out  = y_out_q;
   assign is_inf = is_inf_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
endmodule

// File: tb/tb_jacobian_to_affine.sv
// Self-checking bench for jacobian_to_affine: known answers plus random points against a modular-arithmetic model.
module tb_jacobian_to_affine;
   localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
   localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
   localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [255:0] X = '0, Y = '0, Z = '0;
   logic [255:0] x_out, y_out;
   logic         is_inf, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lmul = 2;

   jacobian_to_affine dut (
      .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .Z(Z),
      .x_out(x_out), .y_out(y_out), .is_inf(is_inf), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] t;
      t = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
      return t[255:0];
   endfunction

   function automatic logic [255:0] inv(input logic [255:0] z);
      logic [255:0] r, base, e;
      r = 256'd1; base = z; e = P - 256'd2;
      for (int k = 0; k < 256; k++) begin
         if (e[k]) r = mm(r, base);
         base = mm(base, base);
      end
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v % P;
   endfunction

   // one conversion; latency counted from the start cycle to the done cycle
   task automatic run_conv(input logic [255:0] xi, input logic [255:0] yi, input logic [255:0] zi,
                           output logic [255:0] xo, output logic [255:0] yo, output logic inf,
                           output int lat, output int pulses, output int lm, output logic busy1,
                           output bit timeout);
      int t0, fs, fd;
      @(posedge clk); #1;
      X = xi; Y = yi; Z = zi; start = 1'b1; t0 = cyc;
      pulses = 0; fs = -1; fd = -1; lat = -1; timeout = 1'b1; busy1 = 1'b0;
      xo = '0; yo = '0; inf = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         @(posedge clk); #1;
         if (n == 0) busy1 = busy;
         start = 1'b0; X = rnd256(); Y = rnd256(); Z = rnd256();
         if (dut.u_mul.start) begin pulses++; if (fs < 0) fs = cyc; end
         if (dut.u_mul.done && fd < 0) fd = cyc;
         if (done) begin
            lat = cyc - t0; xo = x_out; yo = y_out; inf = is_inf; timeout = 1'b0;
            break;
         end
      end
      lm = (fs >= 0 && fd >= 0) ? (fd - fs) : 0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (x_out !== '0)   begin errors++; $display("FAIL reset_x got %h exp 0", x_out); end
      checks++; if (y_out !== '0)   begin errors++; $display("FAIL reset_y got %h exp 0", y_out); end
      checks++; if (is_inf !== 1'b0) begin errors++; $display("FAIL reset_inf got %b exp 0", is_inf); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [255:0] xo, yo; logic inf, b1; int lat, pul, lm; bit to;
      run_conv(256'd4, 256'd8, 256'd2, xo, yo, inf, lat, pul, lm, b1, to);
      lmul = lm;
      checks++; if (to)            begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
      checks++; if (xo !== 256'd1) begin errors++; $display("FAIL basic_x got %h exp 1", xo); end
      checks++; if (yo !== 256'd1) begin errors++; $display("FAIL basic_y got %h exp 1", yo); end
      checks++; if (inf !== 1'b0)  begin errors++; $display("FAIL basic_inf got %b exp 0", inf); end
      checks++; if (b1 !== 1'b1)   begin errors++; $display("FAIL basic_busy got %b exp 1", b1); end
      checks++; if (pul != 507)    begin errors++; $display("FAIL basic_pulses got %0d exp 507", pul); end
      checks++; if (lm < 1)        begin errors++; $display("FAIL basic_mul_latency got %0d exp >=1", lm); end
      checks++; if (lat != 2 + 507 * lm) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, 2 + 507 * lm); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_neg;
      logic [255:0] xo, yo; logic inf, b1; int lat, pul, lm; bit to;
      run_conv(256'd5, 256'd7, P - 256'd1, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (xo !== 256'd5)     begin errors++; $display("FAIL neg_x got %h exp 5", xo); end
      checks++; if (yo !== P - 256'd7) begin errors++; $display("FAIL neg_y got %h exp %h", yo, P - 256'd7); end
   endtask

   task automatic test_generator;
      logic [255:0] xo, yo; logic inf, b1; int lat, pul, lm; bit to;
      run_conv(mm(256'd4, GX), mm(256'd8, GY), 256'd2, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (xo !== GX) begin errors++; $display("FAIL gen_x got %h exp %h", xo, GX); end
      checks++; if (yo !== GY) begin errors++; $display("FAIL gen_y got %h exp %h", yo, GY); end
   endtask

   task automatic test_random;
      logic [255:0] xi, yi, zi, zinv, ex, ey, xo, yo; logic inf, b1; int lat, pul, lm; bit to;
      for (int t = 0; t < 3; t++) begin
         xi = rnd256(); yi = rnd256();
         do zi = rnd256(); while (zi == '0);
         zinv = inv(zi);
         ex = mm(xi, mm(zinv, zinv));
         ey = mm(yi, mm(zinv, mm(zinv, zinv)));
         run_conv(xi, yi, zi, xo, yo, inf, lat, pul, lm, b1, to);
         checks++; if (xo !== ex)    begin errors++; $display("FAIL rand%0d_x got %h exp %h", t, xo, ex); end
         checks++; if (yo !== ey)    begin errors++; $display("FAIL rand%0d_y got %h exp %h", t, yo, ey); end
         checks++; if (inf !== 1'b0) begin errors++; $display("FAIL rand%0d_inf got %b exp 0", t, inf); end
      end
   endtask

   task automatic test_zero;
      logic [255:0] xo, yo; logic inf, b1; int lat, pul, lm; bit to;
      run_conv(rnd256(), rnd256(), 256'd0, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (inf !== 1'b1) begin errors++; $display("FAIL zero_inf got %b exp 1", inf); end
      checks++; if (xo !== '0)    begin errors++; $display("FAIL zero_x got %h exp 0", xo); end
      checks++; if (yo !== '0)    begin errors++; $display("FAIL zero_y got %h exp 0", yo); end
      checks++; if (lat != 2)     begin errors++; $display("FAIL zero_latency got %0d exp 2", lat); end
      checks++; if (pul != 0)     begin errors++; $display("FAIL zero_pulses got %0d exp 0", pul); end
   endtask

   task automatic test_z1;
      logic [255:0] xo, yo; logic inf, b1; int lat, pul, lm, exp_lat; bit to;
`ifdef J2A_Z1_BYPASS_EN
      exp_lat = 2;
`else
      exp_lat = 2 + 507 * lmul;
`endif
      run_conv(256'd9, 256'd27, 256'd1, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (xo !== 256'd9)  begin errors++; $display("FAIL z1_x got %h exp 9", xo); end
      checks++; if (yo !== 256'd27) begin errors++; $display("FAIL z1_y got %h exp 27", yo); end
      checks++; if (inf !== 1'b0)   begin errors++; $display("FAIL z1_inf got %b exp 0", inf); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL z1_latency got %0d exp %0d", lat, exp_lat); end
   endtask

   task automatic test_reset_mid;
      int pul, t0, lat;
      bit saw_done, finished;
      logic [255:0] xo, yo;
      @(posedge clk); #1;
      X = rnd256(); Y = rnd256(); Z = 256'd5; start = 1'b1;
      pul = 0; saw_done = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) saw_done = 1'b1;
         if (dut.u_mul.start) pul++;
         if (pul == 100) break;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (pul != 100)      begin errors++; $display("FAIL rstmid_reach got %0d exp 100", pul); end
      checks++; if (x_out !== '0)    begin errors++; $display("FAIL rstmid_x got %h exp 0", x_out); end
      checks++; if (y_out !== '0)    begin errors++; $display("FAIL rstmid_y got %h exp 0", y_out); end
      checks++; if (is_inf !== 1'b0) begin errors++; $display("FAIL rstmid_inf got %b exp 0", is_inf); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      for (int n = 0; n < 20; n++) begin
         if (done || busy) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (saw_done) begin errors++; $display("FAIL rstmid_nodone got activity exp none"); end

      X = 256'd9; Y = 256'd27; Z = 256'd3; start = 1'b1; t0 = cyc;
      finished = 1'b0; lat = -1; xo = '0; yo = '0;
      for (int n = 0; n < 5000; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (n == 10) begin X = 256'd1; Y = 256'd2; Z = 256'd0; start = 1'b1; end
         if (done) begin finished = 1'b1; lat = cyc - t0; xo = x_out; yo = y_out; break; end
      end
      checks++; if (!finished)      begin errors++; $display("FAIL fresh_timeout got timeout exp done"); end
      checks++; if (xo !== 256'd1)  begin errors++; $display("FAIL fresh_x got %h exp 1", xo); end
      checks++; if (yo !== 256'd1)  begin errors++; $display("FAIL fresh_y got %h exp 1", yo); end
      checks++; if (is_inf !== 1'b0) begin errors++; $display("FAIL fresh_inf got %b exp 0", is_inf); end
      checks++; if (lat != 2 + 507 * lmul) begin errors++; $display("FAIL fresh_latency got %0d exp %0d", lat, 2 + 507 * lmul); end
   endtask

   task automatic test_back_to_back;
      logic [255:0] xo, yo; logic inf, b1; int lat, pul, lm; bit to;
      run_conv(rnd256(), rnd256(), 256'd0, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (lat != 2) begin errors++; $display("FAIL b2b_zero_latency got %0d exp 2", lat); end
      run_conv(256'd4, 256'd8, 256'd2, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (xo !== 256'd1 || yo !== 256'd1) begin errors++; $display("FAIL b2b_xy got %h %h exp 1 1", xo, yo); end
      checks++; if (lat != 2 + 507 * lmul) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, 2 + 507 * lmul); end
      run_conv(256'd3, 256'd3, 256'd0, xo, yo, inf, lat, pul, lm, b1, to);
      checks++; if (inf !== 1'b1 || lat != 2) begin errors++; $display("FAIL b2b_zero2 got inf=%b lat=%0d exp inf=1 lat=2", inf, lat); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_neg;
      test_generator;
      test_random;
      test_zero;
      test_z1;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jacobian_to_affine.md
# jacobian_to_affine

Converts a secp256k1 point from Jacobian coordinates (X, Y, Z) to affine coordinates (x = X/Z², y = Y/Z³ mod P). It is the output end of the scalar-multiplication datapath: point-add and point-double results are kept in Jacobian form, and this block produces the final affine coordinates. It shares the existing `mod_mul` multiplier through its start/done pulse handshake. Z⁻¹ is computed as Z^(P−2) by left-to-right square-and-multiply.

## Interface
Parameters:
- `P`, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F — field prime (localparam).
- `EXP`, P−2 — inversion exponent (localparam; bit 255 is 1, popcount 249).

Ports:
- `clk` — input, 1 — clock.
- `rst` — input, 1 — reset; synchronous, active-high.
- `start` — input, 1 — one-cycle request pulse; sampled only in IDLE.
- `X`, `Y`, `Z` — input, 256 each — Jacobian coordinates; all < P; captured on accepted `start`.
- `x_out`, `y_out` — output, 256 each — affine result; held until the next accepted `start`.
- `is_inf` — output, 1 — result is the point at infinity (Z == 0).
- `busy` — output, 1 — high from the cycle after an accepted `start` until `done`.
- `done` — output, 1 — one-cycle completion pulse.

## Operation
- One internal `mod_mul` instance, with ports `start`/`a`/`b`/`result`/`done`, reset by `rst`. Only one multiply is outstanding at a time.
- Registers: latched `Xr`, `Yr`, `Zr`; accumulator `acc`; bit index `i` (8 bit); `zi2` holding Z⁻².
- States:
  - **IDLE**: on `start`, latch the inputs and clear `is_inf`.
    - If Z == 0: `x_out` = 0, `y_out` = 0, `is_inf` = 1, go to DONE.
    - Otherwise: `acc` ← Z, `i` ← 254, go to SQ.
  - **SQ**: issue `acc·acc`. On mul done: `acc` ← result.
    - If EXP[i] = 1, go to MUL.
    - Else if i == 0, go to ZI2.
    - Else i ← i−1 and stay in SQ.
  - **MUL**: issue `acc·Zr`. On mul done: `acc` ← result. If i == 0 go to ZI2; else i ← i−1, go to SQ.
  - **ZI2**: issue `acc·acc` → `zi2`.
  - **XM**: issue `Xr·zi2` → `x_out`.
  - **ZI3**: issue `zi2·acc` → `acc` (now Z⁻³).
  - **YM**: issue `Yr·acc` → `y_out`, then go to DONE.
  - **DONE**: `done` = 1 for one cycle, go to IDLE.
- The multiplier start is a one-cycle pulse. The next operation is issued in the same cycle the previous mul done is captured.
- Total multiplies for Z ≠ 0: 255 squarings + 248 multiplies + 4 finishing = **507**.
- `start` while busy is ignored. Input changes after acceptance are ignored.
- The block does no on-curve check; any nonzero Z < P is converted.

## Timing
- Reset values: `x_out` = 0, `y_out` = 0, `is_inf` = 0, `busy` = 0, `done` = 0; state IDLE; multiplier start low.
- `rst` mid-operation: next cycle is IDLE with all outputs at reset values. An in-flight `mod_mul` result is discarded.
- Z == 0: `done` is asserted 2 cycles after the `start` cycle.
- Z ≠ 0: the first `mod_mul` start pulse occurs in the cycle after the `start` cycle.
  - Let L = cycles from a `mod_mul` start pulse to its done pulse.
  - Latency from `start` to `done` = 2 + 507·L cycles.
- `x_out` becomes valid before `done`. Both outputs are stable when `done` is high.
- A new `start` is accepted in the cycle after `done`, i.e. back-to-back conversions.

## Configuration
- `J2A_Z1_BYPASS_EN`
  - Defined: in IDLE, Z == 1 bypasses all multiplies. `x_out` = X, `y_out` = Y, and `done` follows 2 cycles after `start`, as in the Z == 0 path.
  - Undefined: Z == 1 takes the full 507-multiply path. Results are bit-identical either way.

## Test plan
- X = 4, Y = 8, Z = 2 → `x_out` = 1, `y_out` = 1, `is_inf` = 0; exactly 507 multiplier start pulses; `done` high exactly one cycle.
- X = 5, Y = 7, Z = P−1 → `x_out` = 5, `y_out` = P−7.
- Generator G: X = 4·Gx mod P, Y = 8·Gy mod P, Z = 2 → `x_out` = Gx (79BE667E…16F81798), `y_out` = Gy (483ADA77…FB10D4B8).
- Z = 0 with arbitrary X/Y → `is_inf` = 1, `x_out` = `y_out` = 0, `done` 2 cycles after `start`.
- Z = 1, X = 9, Y = 27 → `x_out` = 9, `y_out` = 27. With `J2A_Z1_BYPASS_EN` the latency is 2 cycles; without it the latency is 2 + 507·L.
- Assert `rst` during SQ at the 100th multiply → outputs cleared next cycle, no `done`. A fresh `start` with X = 9, Y = 27, Z = 3 → `x_out` = 1, `y_out` = 1. A second `start` pulsed while busy has no effect.
